// File: rtl/gfx_pkg.sv
// Shared fixed-point constants, memory word layouts and the viewport FSM state type
// for the post-MVP vertex stages.
package gfx_pkg;

    localparam logic [31:0] Q16_ONE     = 32'h0001_0000;
    localparam int          Q_FRAC_BITS = 16;

    // clip-space vertex: x, y, z, w in consecutive words
    localparam int CLIP_X     = 0;
    localparam int CLIP_Y     = 1;
    localparam int CLIP_Z     = 2;
    localparam int CLIP_W     = 3;
    localparam int CLIP_WORDS = 4;

    // screen-space vertex: {sy, sx} then z
    localparam logic [31:0] SCR_XY    = 32'd0;
    localparam logic [31:0] SCR_Z     = 32'd1;
    localparam logic [31:0] SCR_WORDS = 32'd2;

    localparam int          DIV_CYCLES = 34;
    localparam logic [31:0] SAT_POS    = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG    = 32'h8000_0000;

    localparam logic [31:0] REJECT_XY = 32'hFFFF_FFFF;
    localparam logic [31:0] REJECT_Z  = 32'h8000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_RD_WAIT,
        S_DIV_X,
        S_DIV_Y,
        S_DIV_Z,
        S_VIEWPORT,
        S_WR0,
        S_WR1
    } vv_state_t;

    function automatic logic [15:0] clamp_px(input logic signed [48:0] v, input logic [15:0] maxv);
        if (v < 0)
            return 16'd0;
        if (v > $signed({33'd0, maxv}))
            return maxv;
        return v[15:0];
    endfunction

    function automatic logic signed [32:0] abs33(input logic [31:0] v);
        logic signed [32:0] s;
        s = $signed({v[31], v});
        return (s < 0) ? -s : s;
    endfunction

endpackage

// File: rtl/q16_divider.sv
// Sequential signed Q16.16 divider: quo = sat32((num << 16) / den), truncating toward zero.
// DIV_CYCLES from start to done; den == 0 saturates by the sign of num after one cycle.
module q16_divider
    import gfx_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num,
    input  logic [31:0] den,
    output logic [31:0] quo,
    output logic        done
);

    localparam int ITERS = DIV_CYCLES - 2;

    logic        busy, neg, ovf;
    logic [5:0]  iter;
    logic [32:0] rem, trial;
    logic [31:0] n_lo, q, dmag;
    logic [31:0] num_mag, den_mag;

    assign num_mag = num[31] ? -num : num;
    assign den_mag = den[31] ? -den : den;
    assign trial   = {rem[31:0], n_lo[31]};

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            quo  <= '0;
            iter <= '0;
            rem  <= '0;
            n_lo <= '0;
            q    <= '0;
            dmag <= '0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (den == 32'd0) begin
                    quo  <= num[31] ? SAT_NEG : SAT_POS;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    // Upper 16 dividend bits seed the remainder; if they already reach the
                    // divisor the quotient needs more than 32 bits and will saturate.
                    rem  <= {17'd0, num_mag[31:16]};
                    n_lo <= {num_mag[15:0], 16'd0};
                    dmag <= den_mag;
                    neg  <= num[31] ^ den[31];
                    ovf  <= ({16'd0, num_mag[31:16]} >= den_mag);
                    q    <= '0;
                    iter <= '0;
                    busy <= 1'b1;
                end
            end else if (busy) begin
                if (iter == 6'(ITERS)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (ovf)
                        quo <= neg ? SAT_NEG : SAT_POS;
                    else if (!neg)
                        quo <= q[31] ? SAT_POS : q;
                    else
                        quo <= (q > SAT_NEG) ? SAT_NEG : -q;
                end else begin
                    if (trial >= {1'b0, dmag}) begin
                        rem <= trial - {1'b0, dmag};
                        q   <= {q[30:0], 1'b1};
                    end else begin
                        rem <= trial;
                        q   <= {q[30:0], 1'b0};
                    end
                    n_lo <= {n_lo[30:0], 1'b0};
                    iter <= iter + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vertex_viewport.sv
// Perspective divide + viewport transform from clip-space vertex RAM to screen-space vertices.
// Optional clip rejection to a sentinel vertex: define VERTEX_VIEWPORT_CLIP_REJECT_EN.
module vertex_viewport
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int RD_LAT   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] count,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    output logic        done,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_wren
);

    localparam logic [15:0]        MAX_X  = 16'(SCREEN_W - 1);
    localparam logic [15:0]        MAX_Y  = 16'(SCREEN_H - 1);
    localparam logic signed [48:0] HALF_W = 49'(SCREEN_W / 2);
    localparam logic signed [48:0] HALF_H = 49'(SCREEN_H / 2);
    localparam logic signed [48:0] ONE_49 = 49'(Q16_ONE);

    vv_state_t                   state;
    logic [31:0]                 cnt, vidx, rd_ptr, vtx_wr;
    logic [1:0]                  issue_idx, cap_idx;
    logic [RD_LAT:0]             vld_pipe;
    logic [CLIP_WORDS-1:0][31:0] clip;
    logic [31:0]                 ndc_x, ndc_y, ndc_z, word0, word1;
    logic                        div_start, div_done;
    logic [31:0]                 div_num, div_quo;
    logic signed [48:0]          vx, vy;
    logic                        reject;

    assign done = (state == S_IDLE);

    always_comb begin
        div_num = clip[CLIP_X];
        if (state == S_DIV_Y)
            div_num = clip[CLIP_Y];
        else if (state == S_DIV_Z)
            div_num = clip[CLIP_Z];
    end

    q16_divider u_div (
        .clock (clock),
        .reset (reset),
        .start (div_start),
        .num   (div_num),
        .den   (clip[CLIP_W]),
        .quo   (div_quo),
        .done  (div_done)
    );

    // 49-bit signed keeps ndc = +/-max plus 1.0 from wrapping before the scale
    assign vx = ($signed({{17{ndc_x[31]}}, ndc_x}) + ONE_49) * HALF_W;
    assign vy = (ONE_49 - $signed({{17{ndc_y[31]}}, ndc_y})) * HALF_H;

`ifdef VERTEX_VIEWPORT_CLIP_REJECT_EN
    logic signed [32:0] w_s;
    assign w_s    = $signed({clip[CLIP_W][31], clip[CLIP_W]});
    assign reject = (w_s <= 0) || (abs33(clip[CLIP_X]) > w_s) ||
                    (abs33(clip[CLIP_Y]) > w_s) || (abs33(clip[CLIP_Z]) > w_s);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            mem_wren       <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            vld_pipe       <= '0;
            div_start      <= 1'b0;
            cnt            <= '0;
            vidx           <= '0;
            rd_ptr         <= '0;
            vtx_wr         <= '0;
            issue_idx      <= '0;
            cap_idx        <= '0;
            clip           <= '0;
            ndc_x          <= '0;
            ndc_y          <= '0;
            ndc_z          <= '0;
            word0          <= '0;
            word1          <= '0;
        end else begin
            mem_wren  <= 1'b0;
            div_start <= 1'b0;
            // vld_pipe[0] marks a live read address; it lands RD_LAT cycles later
            vld_pipe  <= {vld_pipe[RD_LAT-1:0], 1'b0};
            if (vld_pipe[RD_LAT]) begin
                clip[cap_idx] <= mem_read_data;
                cap_idx       <= cap_idx + 2'd1;
            end

            case (state)
                S_IDLE: if (start) begin
                    cnt    <= count;
                    rd_ptr <= src_base;
                    vtx_wr <= dst_base;
                    vidx   <= '0;
                    state  <= S_LOAD;
                end
                S_LOAD: begin
                    issue_idx <= '0;
                    cap_idx   <= '0;
                    state     <= (cnt == 32'd0) ? S_IDLE : S_RD;
                end
                S_RD: begin
                    mem_read_addr <= rd_ptr;
                    rd_ptr        <= rd_ptr + 32'd1;
                    vld_pipe[0]   <= 1'b1;
                    issue_idx     <= issue_idx + 2'd1;
                    if (issue_idx == 2'(CLIP_WORDS - 1))
                        state <= S_RD_WAIT;
                end
                S_RD_WAIT: if (vld_pipe[RD_LAT] && cap_idx == 2'(CLIP_WORDS - 1)) begin
                    state     <= S_DIV_X;
                    div_start <= 1'b1;
                end
                S_DIV_X: if (div_done) begin
                    ndc_x     <= div_quo;
                    state     <= S_DIV_Y;
                    div_start <= 1'b1;
                end
                S_DIV_Y: if (div_done) begin
                    ndc_y     <= div_quo;
                    state     <= S_DIV_Z;
                    div_start <= 1'b1;
                end
                S_DIV_Z: if (div_done) begin
                    ndc_z <= div_quo;
                    state <= S_VIEWPORT;
                end
                S_VIEWPORT: begin
                    word0 <= reject ? REJECT_XY :
                             {clamp_px(vy >>> Q_FRAC_BITS, MAX_Y), clamp_px(vx >>> Q_FRAC_BITS, MAX_X)};
                    word1 <= reject ? REJECT_Z : ndc_z;
                    state <= S_WR0;
                end
                S_WR0: begin
                    mem_write_addr <= vtx_wr + SCR_XY;
                    mem_write_data <= word0;
                    mem_wren       <= 1'b1;
                    state          <= S_WR1;
                end
                S_WR1: begin
                    mem_write_addr <= vtx_wr + SCR_Z;
                    mem_write_data <= word1;
                    mem_wren       <= 1'b1;
                    vtx_wr         <= vtx_wr + SCR_WORDS;
                    vidx           <= vidx + 32'd1;
                    issue_idx      <= '0;
                    state          <= (vidx + 32'd1 == cnt) ? S_IDLE : S_RD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
